// File: rtl/beat_timing_gen.sv
// Beat/phase timing generator: T1..T3 phase strobes, one-hot W1..W3 beats.
// Define TIMING_STEP_EN to add the dp single-beat step input.
module beat_timing_gen #(
   parameter int PHASE_CYCLES   = 1,
   parameter int QD_SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic qd,
   input  logic short,
   input  logic long,
   input  logic stop,
`ifdef TIMING_STEP_EN
   input  logic dp,
`endif
   output logic t1,
   output logic t2,
   output logic t3,
   output logic w1,
   output logic w2,
   output logic w3,
   output logic running
);

   localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

   typedef enum logic {
      HALTED,
      RUN
   } state_t;

   state_t                    state_q;
   logic [2:0]                t_q;
   logic [2:0]                w_q;
   logic [2:0]                w_d;
   logic                      run_q;
   logic [CW-1:0]             cnt_q;
   logic [QD_SYNC_STAGES-1:0] qd_sync_q;
   logic                      qd_prev_q;
   logic                      qd_rise;
   logic                      halt_req;

   assign qd_rise = qd_sync_q[QD_SYNC_STAGES-1] & ~qd_prev_q;

`ifdef TIMING_STEP_EN
   assign halt_req = stop | dp;
`else
   assign halt_req = stop;
`endif

   // Synchronise the start button and keep the previous level for edge detect
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         qd_sync_q <= '0;
         qd_prev_q <= 1'b0;
      end else begin
         qd_sync_q <= {qd_sync_q[QD_SYNC_STAGES-2:0], qd};
         qd_prev_q <= qd_sync_q[QD_SYNC_STAGES-1];
      end
   end

   // Beat that follows the current one; short beats long when both are set in W1
   always_comb begin
      w_d = 3'b100;
      unique case (1'b1)
         w_q[2]: w_d = short ? 3'b100 : 3'b010;
         w_q[1]: w_d = long ? 3'b001 : 3'b100;
         default: w_d = 3'b100;
      endcase
   end

   // Phase/beat FSM; controller requests only matter at the end of T3
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= HALTED;
         t_q     <= 3'b000;
         w_q     <= 3'b100;
         run_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            HALTED: begin
               if (qd_rise) begin
                  state_q <= RUN;
                  t_q     <= 3'b100;
                  run_q   <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               if (cnt_q != CNT_LAST) begin
                  cnt_q <= cnt_q + CW'(1);
               end else begin
                  cnt_q <= '0;
                  if (t_q[0]) begin
                     w_q <= w_d;
                     if (halt_req) begin
                        state_q <= HALTED;
                        t_q     <= 3'b000;
                        run_q   <= 1'b0;
                     end else begin
                        t_q <= 3'b100;
                     end
                  end else begin
                     t_q <= t_q >> 1;
                  end
               end
            end
            default: begin
               state_q <= HALTED;
               t_q     <= 3'b000;
               run_q   <= 1'b0;
            end
         endcase
      end
   end

   assign t1      = t_q[2];
   assign t2      = t_q[1];
   assign t3      = t_q[0];
   assign w1      = w_q[2];
   assign w2      = w_q[1];
   assign w3      = w_q[0];
   assign running = run_q;

endmodule

// File: tb/tb_beat_timing_gen.sv
// Randomised bench for beat_timing_gen against a beat/phase reference model.
// Two instances run side by side: PHASE_CYCLES=1 and PHASE_CYCLES=3.
module tb_beat_timing_gen;

   localparam int S = 2;

   logic clk = 1'b0;
   logic clr = 1'b0;
   logic qd  = 1'b0;
   logic sh  = 1'b0;
   logic lg  = 1'b0;
   logic sp  = 1'b0;
   logic dp  = 1'b0;

   // {t1,t2,t3,w1,w2,w3,running}
   logic [6:0] oa;
   logic [6:0] ob;

   typedef struct {
      bit run;
      int beat;
      int ph;
      int cnt;
   } mst_t;

   mst_t m1;
   mst_t m3;
   bit   hist [0:S];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   beat_timing_gen #(.PHASE_CYCLES(1), .QD_SYNC_STAGES(S)) u_pc1 (
      .clk(clk), .clr(clr), .qd(qd),
      .short(sh), .long(lg), .stop(sp),
`ifdef TIMING_STEP_EN
      .dp(dp),
`endif
      .t1(oa[6]), .t2(oa[5]), .t3(oa[4]),
      .w1(oa[3]), .w2(oa[2]), .w3(oa[1]),
      .running(oa[0])
   );

   beat_timing_gen #(.PHASE_CYCLES(3), .QD_SYNC_STAGES(S)) u_pc3 (
      .clk(clk), .clr(clr), .qd(qd),
      .short(sh), .long(lg), .stop(sp),
`ifdef TIMING_STEP_EN
      .dp(dp),
`endif
      .t1(ob[6]), .t2(ob[5]), .t3(ob[4]),
      .w1(ob[3]), .w2(ob[2]), .w3(ob[1]),
      .running(ob[0])
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic mst_t mrst();
      mst_t m;
      m.run  = 1'b0;
      m.beat = 0;
      m.ph   = 0;
      m.cnt  = 0;
      return m;
   endfunction

   // One clock of the timing rules: phase hold, T1->T2->T3, beat rule at T3 end
   function automatic mst_t mstep(mst_t m, int n, bit rise, bit s, bit l,
                                  bit hlt);
      if (!m.run) begin
         if (rise) begin
            m.run = 1'b1;
            m.ph  = 0;
            m.cnt = 0;
         end
      end else if (m.cnt < n - 1) begin
         m.cnt++;
      end else begin
         m.cnt = 0;
         if (m.ph < 2) begin
            m.ph++;
         end else begin
            m.ph = 0;
            if (m.beat == 0)      m.beat = s ? 0 : 1;
            else if (m.beat == 1) m.beat = l ? 2 : 0;
            else                  m.beat = 0;
            if (hlt) m.run = 1'b0;
         end
      end
      return m;
   endfunction

   function automatic logic [6:0] mexp(mst_t m);
      logic [2:0] b;
      logic [2:0] t;
      logic [2:0] w;
      b = 3'b100;
      t = m.run ? (b >> m.ph) : 3'b000;
      w = b >> m.beat;
      return {t, w, m.run};
   endfunction

   task automatic model_reset();
      m1 = mrst();
      m3 = mrst();
      for (int j = 0; j <= S; j++) hist[j] = 1'b0;
   endtask

   task automatic compare(input string tag);
      check({tag, "_pc1"}, oa, mexp(m1));
      check({tag, "_pc3"}, ob, mexp(m3));
      check({tag, "_w1hot"}, $countones(oa[3:1]), 1);
   endtask

   task automatic step(input string tag);
      bit rise;
      bit hlt;
      @(posedge clk);
      if (clr) begin
         model_reset();
      end else begin
         // edge seen when qd was sampled high S edges ago and low S+1 ago
         rise = hist[S-1] && !hist[S];
         hlt  = sp | dp;
         m1 = mstep(m1, 1, rise, sh, lg, hlt);
         m3 = mstep(m3, 3, rise, sh, lg, hlt);
         for (int j = S; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = qd;
      end
      #1;
      compare(tag);
   endtask

   task automatic clr_pulse();
      #2;
      clr = 1'b1;
      model_reset();
      #1;
      compare("clr_async");
      step("clr_hold");
      clr = 1'b0;
   endtask

   int shp [8] = '{0, 8, 8, 0, 2, 4, 0, 3};
   int lgp [8] = '{0, 0, 8, 8, 2, 4, 0, 3};
   int spp [8] = '{0, 0, 0, 0, 1, 2, 8, 1};

   initial begin
      bit found;
      model_reset();
      #2;
      clr = 1'b1;
      #1;
      compare("reset");
      check("reset_out", oa, 7'b0001000);
      check("reset_out3", ob, 7'b0001000);
      step("reset_hold");
      clr = 1'b0;

      qd = 1'b1;
      step("lat1");
      step("lat2");
      check("t1_early", oa[6], 1'b0);
      step("lat3");
      check("t1_lat", oa[6], 1'b1);
      check("run_lat", oa[0], 1'b1);
      for (int k = 0; k < 12; k++) step("free");

      for (int seg = 0; seg < 8; seg++) begin
         for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 4) == 0) qd = ~qd;
            sh = $urandom_range(0, 7) < shp[seg];
            lg = $urandom_range(0, 7) < lgp[seg];
            sp = $urandom_range(0, 7) < spp[seg];
            step($sformatf("seg%0d", seg));
            if ($urandom_range(0, 299) == 0) clr_pulse();
         end
      end

`ifdef TIMING_STEP_EN
      sh = 1'b0;
      lg = 1'b0;
      sp = 1'b0;
      dp = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(0, 3) == 0) qd = ~qd;
         step("dp_step");
      end
      dp = 1'b0;
      for (int k = 0; k < 40; k++) step("dp_free");
`endif

      sh = 1'b0;
      lg = 1'b0;
      sp = 1'b0;
      qd = 1'b0;
      clr_pulse();
      qd = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         step("to_w2t2");
         if (m3.run && m3.beat == 1 && m3.ph == 1 && m3.cnt == 1) found = 1'b1;
      end
      check("reach_w2t2", found, 1'b1);
      check("pre_clr_w2", ob[2], 1'b1);
      clr_pulse();
      check("clr_mid_w", ob[3:1], 3'b100);
      check("clr_mid_t", ob[6:4], 3'b000);
      check("clr_mid_run", ob[0], 1'b0);
      for (int k = 0; k < 8; k++) step("restart");
      check("restart_run", ob[0], 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
